// File: rtl/cache_controller_pkg.sv
// ============================================================================
// Module : cache_controller_pkg
// Brief  : Geometry, address slicing and FSM encodings for the 2-way cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_controller_pkg;

  localparam int SETS    = 64;
  localparam int IDX_W   = 6;
  localparam int TAG_W   = 10;
  localparam int LINE_W  = 64;
  localparam int IDX_LSB = 3;
  localparam int TAG_LSB = 9;
  localparam int WORD_B  = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_THRU = 2'd2;

  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_way.sv
// ============================================================================
// Module : cache_way
// Brief  : One way of the cache: valid/tag/data arrays, combinational lookup,
//          synchronous line fill and word write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_way
  import cache_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  output logic [LINE_W-1:0] line,
  input  logic              fill_en,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              wr_en,
  input  logic              wr_word,
  input  logic [31:0]       wr_data
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign line = data_q[idx];

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_line;
    end else if (wr_en) begin
      if (wr_word) data_q[idx][63:32] <= wr_data;
      else         data_q[idx][31:0]  <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
// Module : cache_controller
// Brief  : 2-way set-associative read cache, write-through/no-allocate, LRU fill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_controller
  import cache_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [31:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              word_sel;
  logic              unused_addr_bits;

  logic [1:0]        state_q, state_d;
  logic [SETS-1:0]   lru_q, lru_d;

  logic [1:0]        way_hit;
  logic [LINE_W-1:0] way_line [2];
  logic              any_hit;
  logic              hit_way;
  logic [LINE_W-1:0] hit_line;
  logic              victim;
  logic              fill;
  logic              wr_hit;

  assign idx              = addr[IDX_LSB +: IDX_W];
  assign tag              = addr[TAG_LSB +: TAG_W];
  assign word_sel         = addr[WORD_B];
  assign unused_addr_bits = ^addr[1:0];

  assign any_hit  = |way_hit;
  assign hit_way  = way_hit[1];
  assign hit_line = way_hit[1] ? way_line[1] : way_line[0];
  assign victim   = lru_q[idx];
  assign sram_wdata = wdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_way
    cache_way u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx),
      .tag       (tag),
      .hit       (way_hit[gi]),
      .line      (way_line[gi]),
      .fill_en   (fill && (victim == 1'(gi))),
      .fill_line (sram_rdata),
      .wr_en     (wr_hit && way_hit[gi]),
      .wr_word   (word_sel),
      .wr_data   (wdata)
    );
  end

  always_comb begin
    state_d    = state_q;
    lru_d      = lru_q;
    fill       = 1'b0;
    wr_hit     = 1'b0;
    ready      = 1'b1;
    rdata      = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    sram_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous read is dropped: the store takes the access slot.
        if (wr_en) begin
          ready   = 1'b0;
          state_d = ST_WR_THRU;
          if (any_hit) begin
            wr_hit     = 1'b1;
            lru_d[idx] = ~hit_way;
          end
        end else if (rd_en) begin
          if (any_hit) begin
            rdata      = line_word(hit_line, word_sel);
            lru_d[idx] = ~hit_way;
          end else begin
            ready   = 1'b0;
            state_d = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        sram_rd_en = 1'b1;
        sram_addr  = {addr[31:3], 3'b000};
        ready      = 1'b0;
        if (sram_ready) begin
          fill       = 1'b1;
          lru_d[idx] = ~victim;
          rdata      = line_word(sram_rdata, word_sel);
          ready      = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WR_THRU: begin
        sram_wr_en = 1'b1;
        sram_addr  = {addr[31:2], 2'b00};
        ready      = 1'b0;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
// Module : tb_cache_controller
// Brief  : Randomized bench for cache_controller against an array-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain per-way arrays plus a "victim way" bit per set.
  bit          m_valid [2][64];
  logic [9:0]  m_tag   [2][64];
  logic [63:0] m_data  [2][64];
  bit          m_lru   [64];

  bit          chk_en = 1'b0;
  bit          e_ready, e_srd, e_swr, chk_rdata, chk_addr;
  logic [31:0] e_rdata, e_addr;
  logic [31:0] obs_rdata;
  bit          obs_srd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_lookup(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][a[8:3]] && m_tag[w][a[8:3]] == a[18:9]) return w;
    return -1;
  endfunction

  function automatic logic [31:0] m_word(input logic [63:0] line, input bit sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 64; s++) begin
      m_valid[0][s] = 1'b0;
      m_valid[1][s] = 1'b0;
      m_lru[s]      = 1'b0;
    end
  endtask

  task automatic set_idle_exp();
    e_ready = 1'b1; e_srd = 1'b0; e_swr = 1'b0; chk_rdata = 1'b0; chk_addr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", ready, e_ready);
      check("sram_rd_en", sram_rd_en, e_srd);
      check("sram_wr_en", sram_wr_en, e_swr);
      check("sram_wdata", sram_wdata, wdata);
      if (chk_rdata) check("rdata", rdata, e_rdata);
      if (chk_addr)  check("sram_addr", sram_addr, e_addr);
    end
    if (ready && rd_en && !wr_en) obs_rdata = rdata;
    if (sram_rd_en) obs_srd = 1'b1;
  end

  // One complete access from request to ready, with random SRAM latency.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input bit fixed, input logic [63:0] fline);
    int          w, lat, s;
    bit          v;
    logic [63:0] line;
    s   = int'(a[8:3]);
    w   = m_lookup(a);
    lat = $urandom_range(0, 3);
    rd_en = rd; wr_en = wr; addr = a; wdata = wd; sram_ready = 1'b0;
    sram_rdata = {$urandom, $urandom};
    e_srd = 1'b0; e_swr = 1'b0; chk_addr = 1'b0; chk_rdata = 1'b0;
    if (wr) begin
      e_ready = 1'b0;
      @(posedge clk); #1;
      if (w >= 0) begin
        if (a[2]) m_data[w][s][63:32] = wd;
        else      m_data[w][s][31:0]  = wd;
        m_lru[s] = (w == 0);
      end
      e_swr = 1'b1; chk_addr = 1'b1; e_addr = {a[31:2], 2'b00};
      repeat (lat) begin @(posedge clk); #1; end
      sram_ready = 1'b1; e_ready = 1'b1;
      @(posedge clk); #1;
      sram_ready = 1'b0;
    end else if (rd && w >= 0) begin
      e_ready = 1'b1; chk_rdata = 1'b1; e_rdata = m_word(m_data[w][s], a[2]);
      @(posedge clk); #1;
      m_lru[s] = (w == 0);
    end else if (rd) begin
      e_ready = 1'b0;
      @(posedge clk); #1;
      e_srd = 1'b1; chk_addr = 1'b1; e_addr = {a[31:3], 3'b000};
      repeat (lat) begin @(posedge clk); #1; end
      line = fixed ? fline : {$urandom, $urandom};
      sram_rdata = line; sram_ready = 1'b1;
      e_ready = 1'b1; chk_rdata = 1'b1; e_rdata = m_word(line, a[2]);
      @(posedge clk); #1;
      sram_ready = 1'b0;
      v = m_lru[s];
      m_valid[v][s] = 1'b1;
      m_tag[v][s]   = a[18:9];
      m_data[v][s]  = line;
      m_lru[s]      = ~v;
    end else begin
      sram_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      sram_ready = 1'b0;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    set_idle_exp();
  endtask

  task automatic rd(input logic [31:0] a);
    access(1'b1, 1'b0, a, 32'h0, 1'b0, 64'h0);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    sram_rdata = '0; sram_ready = 1'b0; obs_rdata = '0; obs_srd = 1'b0;
    e_rdata = '0; e_addr = '0;
    m_clear();
    set_idle_exp();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_sram_rd_en", sram_rd_en, 1'b0);
    check("rst_sram_wr_en", sram_wr_en, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Cold read miss with a known line, then same-line hit on the other word.
    obs_srd = 1'b0;
    access(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 64'hBBBB_0002_AAAA_0001);
    check("t1_miss", obs_srd, 1'b1);
    check("t1_rdata", obs_rdata, 32'hAAAA0001);
    obs_srd = 1'b0;
    rd(32'h204);
    check("t2_hit", obs_srd, 1'b0);
    check("t2_rdata", obs_rdata, 32'hBBBB0002);

    // Set 0 conflicts: LRU replacement sequence.
    rd(32'h400); rd(32'h200);
    obs_srd = 1'b0; rd(32'h004); check("t3_004_miss", obs_srd, 1'b1);
    obs_srd = 1'b0; rd(32'h400); check("t3_400_remiss", obs_srd, 1'b1);
    rd(32'h200);

    // Write-through on a hit updates the cached word; write miss does not allocate.
    rd(32'h200);
    access(1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 64'h0);
    obs_srd = 1'b0; rd(32'h200);
    check("t4_hit_after_wr", obs_srd, 1'b0);
    check("t4_rdata", obs_rdata, 32'h12345678);
    access(1'b0, 1'b1, 32'h800, 32'hCAFEF00D, 1'b0, 64'h0);
    obs_srd = 1'b0; rd(32'h800);
    check("t4_no_allocate", obs_srd, 1'b1);

    // Reset two cycles into a read miss.
    rd_en = 1'b1; addr = 32'hA00; e_ready = 1'b0;
    @(posedge clk); #1;
    e_srd = 1'b1; chk_addr = 1'b1; e_addr = 32'hA00;
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    set_idle_exp(); chk_rdata = 1'b1; e_rdata = 32'h0;
    #1;
    check("t5_rst_sram_rd_en", sram_rd_en, 1'b0);
    check("t5_rst_ready", ready, 1'b1);
    m_clear();
    @(posedge clk); #1;
    rst = 1'b0; chk_rdata = 1'b0;
    obs_srd = 1'b0; rd(32'h200);
    check("t5_miss_after_rst", obs_srd, 1'b1);

    // Simultaneous read and write: only the write-through happens.
    obs_srd = 1'b0;
    access(1'b1, 1'b1, 32'h208, 32'h5A5A5A5A, 1'b0, 64'h0);
    check("t6_no_sram_rd", obs_srd, 1'b0);

    // Random traffic over a small address pool so hits, evictions and writes mix.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int          op;
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3)
        | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFF8_0000);
      op = $urandom_range(0, 19);
      if (op < 10)      access(1'b1, 1'b0, a, 32'h0, 1'b0, 64'h0);
      else if (op < 15) access(1'b0, 1'b1, a, $urandom, 1'b0, 64'h0);
      else if (op < 17) access(1'b1, 1'b1, a, $urandom, 1'b0, 64'h0);
      else              access(1'b0, 1'b0, a, 32'h0, 1'b0, 64'h0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
